// File: rtl/conv_feed_arbiter.sv
// Round-robin arbiter between two frame sources that latches the granted coded frame
// and feeds it to the convolutional decoder two bits per data_ack request.
module conv_feed_arbiter #(
  parameter int unsigned FRAME_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic [FRAME_BITS-1:0] frame_a,
  input  logic                  req_b,
  input  logic [FRAME_BITS-1:0] frame_b,
  output logic                  done_a,
  output logic                  done_b,
  input  logic                  data_ack,
  output logic [1:0]            rx,
  output logic                  seq_rdy,
  output logic                  busy,
  output logic                  owner
);

  localparam int unsigned NSym = FRAME_BITS / 2;
  localparam int unsigned CntW = $clog2(NSym + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDone} state_e;

  state_e                state_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [CntW-1:0]       cnt_q;
  logic [1:0]            rx_q;
  logic                  owner_q;
  logic                  prio_q;

  logic grant_b;
  logic owner_req;
  logic last_sym;

  // B wins when it is the only requester or when both request and B holds priority.
  assign grant_b   = req_b & (~req_a | prio_q);
  assign owner_req = owner_q ? req_b : req_a;
  assign last_sym  = (cnt_q == CntW'(NSym - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      frame_q <= '0;
      cnt_q   <= '0;
      rx_q    <= 2'b00;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_a || req_b) begin
            owner_q <= grant_b;
            frame_q <= grant_b ? frame_b : frame_a;
            cnt_q   <= '0;
            state_q <= StFeed;
          end
        end
        StFeed: begin
          if (!owner_req) begin
            // Abort: the pending data_ack is dropped and rx keeps its last symbol.
            state_q <= StIdle;
            cnt_q   <= '0;
            prio_q  <= ~owner_q;
          end else if (data_ack) begin
            rx_q    <= frame_q[FRAME_BITS-1 -: 2];
            frame_q <= frame_q << 2;
            cnt_q   <= cnt_q + CntW'(1);
            if (last_sym) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          prio_q  <= ~owner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx      = rx_q;
  assign owner   = owner_q;
  assign seq_rdy = (state_q == StFeed);
  assign busy    = (state_q == StFeed) || (state_q == StDone);
  assign done_a  = (state_q == StDone) && !owner_q;
  assign done_b  = (state_q == StDone) && owner_q;

endmodule

// File: tb/tb_conv_feed_arbiter.sv
// Directed bench for conv_feed_arbiter: reset, single frame, contention/streaming,
// abort and asynchronous reset, with hand-computed expected symbols.
module tb_conv_feed_arbiter;

  localparam logic [23:0] FA = 24'b110100010001110000111101;
  localparam logic [23:0] FB = 24'b011011000110100111001001;

  logic        clk;
  logic        rst_n;
  logic        req_a;
  logic        req_b;
  logic        data_ack;
  logic [23:0] frame_a;
  logic [23:0] frame_b;
  logic        done_a;
  logic        done_b;
  logic        seq_rdy;
  logic        busy;
  logic        owner;
  logic [1:0]  rx;

  int vectors;
  int miscompares;

  logic [1:0] exp_a [12];

  conv_feed_arbiter #(.FRAME_BITS(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .frame_a  (frame_a),
    .req_b    (req_b),
    .frame_b  (frame_b),
    .done_a   (done_a),
    .done_b   (done_b),
    .data_ack (data_ack),
    .rx       (rx),
    .seq_rdy  (seq_rdy),
    .busy     (busy),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    data_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({rx, seq_rdy, busy, done_a, done_b} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: rx/seq_rdy/busy/done_a/done_b=%b expected 000000", i,
                 {rx, seq_rdy, busy, done_a, done_b});
      end
      data_ack = ~data_ack;
      req_a = ~req_a;
      req_b = i[1];
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    data_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, owner, rx} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy/owner/rx=%b expected 0000", {busy, owner, rx});
    end
  endtask

  task automatic test_single_a();
    int pulses;
    pulses = 0;
    frame_a = FA;
    req_a = 1'b1;
    @(negedge clk);
    vectors++;
    if (seq_rdy !== 1'b1 || owner !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant: seq_rdy=%b owner=%b expected 1 0", seq_rdy, owner);
    end
    frame_a = 24'hFFFFFF;  // must not affect the latched frame
    for (int k = 0; k < 12; k++) begin
      repeat (3) begin
        @(negedge clk);
        if (done_a === 1'b1) pulses++;
        vectors++;
        if (seq_rdy !== 1'b1 || done_a !== 1'b0) begin
          miscompares++;
          $display("FAIL single_wait sym%0d: seq_rdy=%b done_a=%b expected 1 0", k, seq_rdy,
                   done_a);
        end
      end
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      if (done_a === 1'b1) pulses++;
      vectors++;
      if (rx !== exp_a[k]) begin
        miscompares++;
        $display("FAIL single_rx sym%0d: rx=%b expected %b", k, rx, exp_a[k]);
      end
    end
    vectors++;
    if (done_a !== 1'b1 || seq_rdy !== 1'b0 || busy !== 1'b1 || done_b !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: done_a=%b seq_rdy=%b busy=%b done_b=%b expected 1 0 1 0",
               done_a, seq_rdy, busy, done_b);
    end
    req_a = 1'b0;
    @(negedge clk);
    if (done_a === 1'b1) pulses++;
    vectors++;
    if (pulses != 1 || busy !== 1'b0 || rx !== 2'b01) begin
      miscompares++;
      $display("FAIL single_idle: pulses=%0d busy=%b rx=%b expected 1 0 01", pulses, busy, rx);
    end
  endtask

  task automatic test_contention_stream();
    int hi;
    int lo;
    logic [23:0] fr;
    logic [1:0] es;
    do_reset();
    frame_a = FA;
    frame_b = FB;
    req_a = 1'b1;
    req_b = 1'b1;
    data_ack = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      fr = (f % 2 == 0) ? FA : FB;
      vectors++;
      if (owner !== f[0] || seq_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL contention_owner frame%0d: owner=%b seq_rdy=%b expected %b 1", f, owner,
                 seq_rdy, f[0]);
      end
      hi = 0;
      while (seq_rdy === 1'b1 && hi < 20) begin
        if (hi > 0) begin
          es = fr[23 - 2 * (hi - 1) -: 2];
          vectors++;
          if (rx !== es) begin
            miscompares++;
            $display("FAIL stream_rx frame%0d sym%0d: rx=%b expected %b", f, hi - 1, rx, es);
          end
        end
        hi++;
        @(negedge clk);
      end
      es = fr[1:0];
      vectors++;
      if (hi != 12 || rx !== es) begin
        miscompares++;
        $display("FAIL stream_len frame%0d: feed cycles=%0d last rx=%b expected 12 %b", f, hi,
                 rx, es);
      end
      vectors++;
      if (done_a !== ~f[0] || done_b !== f[0]) begin
        miscompares++;
        $display("FAIL contention_done frame%0d: done_a=%b done_b=%b expected %b %b", f, done_a,
                 done_b, ~f[0], f[0]);
      end
      if (f == 3) begin
        req_a = 1'b0;
        req_b = 1'b0;
        data_ack = 1'b0;
      end else begin
        lo = 0;
        while (seq_rdy !== 1'b1 && lo < 10) begin
          lo++;
          @(negedge clk);
        end
        vectors++;
        if (lo != 2) begin
          miscompares++;
          $display("FAIL contention_gap frame%0d: gap=%0d expected 2", f, lo);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_reset();
    frame_a = FA;
    frame_b = FB;
    req_a = 1'b1;
    req_b = 1'b1;
    data_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (seq_rdy !== 1'b1 || owner !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_grant: seq_rdy=%b owner=%b expected 1 0", seq_rdy, owner);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (rx !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_sym5: rx=%b expected 00", rx);
    end
    req_a = 1'b0;
    @(negedge clk);
    vectors++;
    if (seq_rdy !== 1'b0 || done_a !== 1'b0 || busy !== 1'b0 || rx !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_idle: seq_rdy=%b done_a=%b busy=%b rx=%b expected 0 0 0 00", seq_rdy,
               done_a, busy, rx);
    end
    @(negedge clk);
    vectors++;
    if (seq_rdy !== 1'b1 || owner !== 1'b1 || rx !== 2'b00 || done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_regrant: seq_rdy=%b owner=%b rx=%b done_a=%b expected 1 1 00 0",
               seq_rdy, owner, rx, done_a);
    end
    @(negedge clk);
    vectors++;
    if (rx !== FB[23:22]) begin
      miscompares++;
      $display("FAIL abort_b_sym0: rx=%b expected %b", rx, FB[23:22]);
    end
    req_b = 1'b0;
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    frame_a = FA;
    req_a = 1'b1;
    data_ack = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    vectors++;
    if (rx !== 2'b11 || seq_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: rx=%b seq_rdy=%b expected 11 1", rx, seq_rdy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rx, seq_rdy, busy, done_a, done_b, owner} !== 7'b0) begin
      miscompares++;
      $display("FAIL areset_now: rx/seq_rdy/busy/done_a/done_b/owner=%b expected 0000000",
               {rx, seq_rdy, busy, done_a, done_b, owner});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (seq_rdy !== 1'b1 || rx !== 2'b00) begin
      miscompares++;
      $display("FAIL areset_regrant: seq_rdy=%b rx=%b expected 1 00", seq_rdy, rx);
    end
    @(negedge clk);
    vectors++;
    if (rx !== 2'b11) begin
      miscompares++;
      $display("FAIL areset_sym0: rx=%b expected 11", rx);
    end
    @(negedge clk);
    vectors++;
    if (rx !== 2'b01) begin
      miscompares++;
      $display("FAIL areset_sym1: rx=%b expected 01", rx);
    end
    req_a = 1'b0;
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_a = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
              2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01};
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    data_ack = 1'b0;
    frame_a = '0;
    frame_b = '0;
    test_reset();
    test_single_a();
    test_contention_stream();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
